// File: rtl/mips_regfile_mp.sv
// mips_regfile_mp: parametrised multi-port register file for the MIPS pipeline.
// Asynchronous (combinational) read ports feed the ID stage; two write ports are
// committed by the WB stage on the rising edge. A hardware clear sequencer zeroes
// every entry after reset, so no file preload is needed. Register 0 can be
// hardwired to zero, and same-cycle write data can be bypassed to the readers.
module mips_regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_RD*ADDR_W-1:0]   ReadReg,
    output logic [NUM_RD*DATA_W-1:0]   ReadData,
    input  logic [ADDR_W-1:0]          WriteReg0,
    input  logic [DATA_W-1:0]          WriteData0,
    input  logic                       RegWrite0,
    input  logic [ADDR_W-1:0]          WriteReg1,
    input  logic [DATA_W-1:0]          WriteData1,
    input  logic                       RegWrite1,
    output logic                       Busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic                busy_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    // Writes to entry 0 are dropped when it is hardwired to zero.
    logic wr0_allowed;
    logic wr1_allowed;
    logic run_commit;

    assign wr0_allowed = RegWrite0 && !((ZERO_REG != 0) && (WriteReg0 == '0));
    assign wr1_allowed = RegWrite1 && !((ZERO_REG != 0) && (WriteReg1 == '0));
    // A reset edge aborts RUN, so nothing is committed on that edge.
    assign run_commit  = (state_q == ST_RUN) && !RST;

    // Clear sequencer: walks every entry once after reset, then enters RUN.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values and simulation matches the synthesised flops.
        if (RST) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q   <= ST_CLEAR;
                    clr_cnt_q <= '0;
                    busy_q    <= 1'b1;
                end
            endcase
        end
    end

    assign Busy = busy_q;

    // Storage: cleared entry by entry by the sequencer, written by WB in RUN.
    always_ff @(posedge CLK) begin
        // NOTE: the array has no reset branch; resetting it directly would turn
        // it into DEPTH*DATA_W flops with a reset net. The sequencer clears it.
        if (!RST) begin
            if (state_q == ST_CLEAR) begin
                mem_q[clr_cnt_q] <= '0;
            end else if (run_commit) begin
                if (wr0_allowed) begin
                    mem_q[WriteReg0] <= WriteData0;
                end
                // Port 1 is assigned last so it wins on an address collision.
                if (wr1_allowed) begin
                    mem_q[WriteReg1] <= WriteData1;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] rd_val;

        assign rd_addr = ReadReg[k*ADDR_W +: ADDR_W];

        // Read mux: later assignments carry higher priority (clear masks all).
        always_comb begin
            // NOTE: a full default first keeps this block free of inferred latches.
            rd_val = mem_q[rd_addr];
            if ((BYPASS != 0) && RegWrite0 && (WriteReg0 == rd_addr)) begin
                rd_val = WriteData0;
            end
            if ((BYPASS != 0) && RegWrite1 && (WriteReg1 == rd_addr)) begin
                rd_val = WriteData1;
            end
            if ((ZERO_REG != 0) && (rd_addr == '0)) begin
                rd_val = '0;
            end
            if (state_q == ST_CLEAR) begin
                rd_val = '0;
            end
        end

        assign ReadData[k*DATA_W +: DATA_W] = rd_val;
    end

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Bench for mips_regfile_mp: a bypassing and a non-bypassing instance share all
// inputs and are compared each step against an array model of the register file.
module tb_mips_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data_b;
    logic [NR*DW-1:0]  rd_data_nb;
    logic [AW-1:0]     wa0, wa1;
    logic [DW-1:0]     wd0, wd1;
    logic              we0, we1;
    logic              busy_b, busy_nb;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: register contents plus edges left in the clear sequence.
    logic [DW-1:0] ref_mem [DEPTH];
    int            clr_left = DEPTH;

    always #5 clk = ~clk;

    mips_regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .CLK(clk), .RST(rst), .ReadReg(rd_addr), .ReadData(rd_data_b),
        .WriteReg0(wa0), .WriteData0(wd0), .RegWrite0(we0),
        .WriteReg1(wa1), .WriteData1(wd1), .RegWrite1(we1), .Busy(busy_b)
    );

    mips_regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
        .CLK(clk), .RST(rst), .ReadReg(rd_addr), .ReadData(rd_data_nb),
        .WriteReg0(wa0), .WriteData0(wd0), .RegWrite0(we0),
        .WriteReg1(wa1), .WriteData1(wd1), .RegWrite1(we1), .Busy(busy_nb)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Expected read value from the file's read rules, given the current inputs.
    function automatic logic [DW-1:0] ref_read(input int a, input bit byp);
        if (clr_left > 0) return '0;
        if (a == 0) return '0;
        if (byp && we1 && int'(wa1) == a) return wd1;
        if (byp && we0 && int'(wa0) == a) return wd0;
        return ref_mem[a];
    endfunction

    task automatic set_read(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic idle_writes();
        we0 = 1'b0; we1 = 1'b0;
        wa0 = '0;   wa1 = '0;
        wd0 = '0;   wd1 = '0;
    endtask

    // Compare every read port and Busy on both instances against the model.
    task automatic check_ports(input string tag);
        int a;
        #1;
        for (int p = 0; p < NR; p++) begin
            a = int'(rd_addr[p*AW +: AW]);
            check($sformatf("%s byp p%0d r%0d", tag, p, a), rd_data_b[p*DW +: DW], ref_read(a, 1'b1));
            check($sformatf("%s nob p%0d r%0d", tag, p, a), rd_data_nb[p*DW +: DW], ref_read(a, 1'b0));
        end
        check($sformatf("%s busy byp", tag), DW'(busy_b),  DW'(clr_left > 0));
        check($sformatf("%s busy nob", tag), DW'(busy_nb), DW'(clr_left > 0));
    endtask

    // Advance the model by one rising edge using the inputs presented now.
    task automatic edge_step();
        if (rst) begin
            clr_left = DEPTH;
        end else if (clr_left > 0) begin
            clr_left--;
            if (clr_left == 0) begin
                foreach (ref_mem[i]) ref_mem[i] = '0;
            end
        end else begin
            if (we0 && wa0 != '0) ref_mem[wa0] = wd0;
            if (we1 && wa1 != '0) ref_mem[wa1] = wd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            set_read(0, a);
            set_read(1, DEPTH - 1 - a);
            #1;
            check($sformatf("%s r%0d", tag, a), rd_data_b[DW-1:0], '0);
            check($sformatf("%s nob r%0d", tag, DEPTH - 1 - a), rd_data_nb[2*DW-1:DW], '0);
        end
    endtask

    initial begin
        foreach (ref_mem[i]) ref_mem[i] = '0;
        rst = 1'b1;
        rd_addr = '0;
        idle_writes();

        // T1: one reset edge, then exactly DEPTH busy edges; everything reads 0.
        edge_step();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("t1 busy edge%0d", i), DW'(busy_b), DW'(1));
            check_ports("t1");
            edge_step();
        end
        check("t1 busy done", DW'(busy_b), DW'(0));
        check("t1 busy done nob", DW'(busy_nb), DW'(0));
        read_all_zero("t1 zero");

        // T2: write R5 via port 0, read it back next cycle.
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
        edge_step();
        idle_writes();
        set_read(0, 5); set_read(1, 5);
        check_ports("t2");
        check("t2 r5", rd_data_b[DW-1:0], 32'hDEADBEEF);

        // T3: both ports hit R7; port 1 wins, bypass shows it before the edge.
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
        set_read(0, 7); set_read(1, 7);
        check_ports("t3 pre");
        check("t3 pre bypass", rd_data_b[DW-1:0], 32'h22);
        check("t3 pre nob", rd_data_nb[DW-1:0], 32'h0);
        edge_step();
        idle_writes();
        check_ports("t3 post");
        check("t3 post r7", rd_data_nb[2*DW-1:DW], 32'h22);

        // T4: writes to R0 are dropped and never visible.
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF;
        set_read(0, 0); set_read(1, 0);
        check_ports("t4 pre");
        check("t4 pre r0", rd_data_b[DW-1:0], 32'h0);
        edge_step();
        idle_writes();
        check_ports("t4 post");
        check("t4 post r0", rd_data_b[2*DW-1:DW], 32'h0);

        // T5: same-cycle read of R9 while writing it.
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hAAAA;
        edge_step();
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h1234;
        set_read(0, 9); set_read(1, 9);
        check_ports("t5 pre");
        check("t5 pre bypass", rd_data_b[DW-1:0], 32'h1234);
        check("t5 pre nob old", rd_data_nb[DW-1:0], 32'hAAAA);
        edge_step();
        idle_writes();
        check_ports("t5 post");
        check("t5 post nob", rd_data_nb[DW-1:0], 32'h1234);

        // T6: fill R1..R31 with their index, alternating write ports.
        for (int i = 1; i < DEPTH; i++) begin
            idle_writes();
            if (i % 2 == 1) begin
                we1 = 1'b1; wa1 = AW'(i); wd1 = DW'(i);
            end else begin
                we0 = 1'b1; wa0 = AW'(i); wd0 = DW'(i);
            end
            set_read(0, i); set_read(1, i - 1);
            check_ports("t6 fill");
            edge_step();
        end
        idle_writes();
        set_read(0, 31); set_read(1, 17);
        check_ports("t6 filled");
        check("t6 r31", rd_data_nb[DW-1:0], 32'd31);

        // Reset, let the clear counter reach 10, then reset again mid-clear.
        rst = 1'b1;
        edge_step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            we0 = 1'b1; wa0 = AW'(i + 1); wd0 = $urandom;
            check_ports("t6 clear1");
            edge_step();
        end
        rst = 1'b1;
        edge_step();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            we0 = 1'b1; wa0 = AW'($urandom_range(1, 31)); wd0 = $urandom;
            we1 = 1'b1; wa1 = AW'($urandom_range(1, 31)); wd1 = $urandom;
            set_read(0, int'(wa0)); set_read(1, int'(wa1));
            check($sformatf("t6 restart busy%0d", i), DW'(busy_b), DW'(1));
            check_ports("t6 clear2");
            edge_step();
        end
        idle_writes();
        check("t6 busy done", DW'(busy_nb), DW'(0));
        read_all_zero("t6 zero");

        // Randomised traffic with occasional resets, checked every cycle.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            we0 = 1'(($urandom_range(0, 3)) != 0);
            we1 = 1'($urandom_range(0, 1));
            wa0 = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wa1 = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wd0 = $urandom;
            wd1 = $urandom;
            for (int p = 0; p < NR; p++) begin
                case ($urandom_range(0, 3))
                    0: set_read(p, int'(wa0));
                    1: set_read(p, int'(wa1));
                    default: set_read(p, int'($urandom_range(0, 31)));
                endcase
            end
            check_ports("rand");
            edge_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
